// File: rtl/core_boot_sequencer.sv
// core_boot_sequencer: boot/run controller for the single-cycle core.
// Loads IMEM words, register preloads and the PC start address over a
// valid/ready command stream. It then releases setup, watches for the halt
// opcode, counts run cycles and reports done.
// Optional feature: define CORE_BOOT_TIMEOUT_EN to end runs at MAX_RUN_CYCLES.
module core_boot_sequencer #(
    parameter logic [31:0] HALT_INSTR     = 32'h00100073,
    parameter int          CNT_W          = 16,
    parameter int          MAX_RUN_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [1:0]       i_cmd_type,
    input  logic [31:0]      i_cmd_addr,
    input  logic [31:0]      i_cmd_data,
    input  logic             i_clear,
    input  logic [31:0]      i_core_inst,
    output logic             o_core_rst_n,
    output logic             o_setup,
    output logic [31:0]      o_inst_mem_addr,
    output logic [31:0]      o_inst_mem_data,
    output logic [4:0]       o_load_reg_addr,
    output logic [31:0]      o_load_reg_data,
    output logic [31:0]      o_start_addr,
    output logic             o_running,
    output logic             o_done,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_cycle_count
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [1:0]       CMD_IMEM  = 2'd0;
    localparam logic [1:0]       CMD_REG   = 2'd1;
    localparam logic [1:0]       CMD_START = 2'd2;
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;

    state_t           state;
    logic             accept;
    logic             halt_seen;
    logic             limit_hit;
    logic [CNT_W-1:0] count_inc;

    // Handshake and status flags decode directly from state.
    assign o_cmd_ready = (state == IDLE) || (state == LOAD);
    assign o_running   = (state == RUN);
    assign o_done      = (state == DONE);
    assign accept      = i_cmd_valid & o_cmd_ready;
    assign halt_seen   = (i_core_inst == HALT_INSTR);
    assign count_inc   = (o_cycle_count == CNT_SAT) ? o_cycle_count : o_cycle_count + 1'b1;

`ifdef CORE_BOOT_TIMEOUT_EN
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(MAX_RUN_CYCLES - 1);
    // Limit fires on the cycle whose increment would land on MAX_RUN_CYCLES.
    assign limit_hit = (o_cycle_count == LIMIT_M1);
`else
    logic unused_max_run;
    assign unused_max_run = (MAX_RUN_CYCLES != 0);
    // No run limit: o_timeout is never set and stays at its reset value of 0.
    assign limit_hit = 1'b0;
`endif

    // Sequencer FSM and all registered core-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            o_core_rst_n    <= 1'b0;
            o_setup         <= 1'b1;
            o_inst_mem_addr <= '0;
            o_inst_mem_data <= '0;
            o_load_reg_addr <= '0;
            o_load_reg_data <= '0;
            o_start_addr    <= '0;
            o_timeout       <= 1'b0;
            o_cycle_count   <= '0;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    // The first accept out of IDLE both enters LOAD and executes the command.
                    if (accept) begin
                        state        <= LOAD;
                        o_core_rst_n <= 1'b1;
                        case (i_cmd_type)
                            CMD_IMEM: begin
                                o_inst_mem_addr <= i_cmd_addr;
                                o_inst_mem_data <= i_cmd_data;
                            end
                            CMD_REG: begin
                                o_load_reg_addr <= i_cmd_addr[4:0];
                                o_load_reg_data <= i_cmd_data;
                            end
                            CMD_START: begin
                                o_start_addr  <= i_cmd_data;
                                o_cycle_count <= '0;
                                o_timeout     <= 1'b0;
                                o_setup       <= 1'b0;
                                state         <= RUN;
                            end
                            default: ; // reserved type: consumed, no effect
                        endcase
                    end
                end
                RUN: begin
                    // Clear beats halt; otherwise the halt cycle itself is counted.
                    if (i_clear) begin
                        state        <= IDLE;
                        o_core_rst_n <= 1'b0;
                        o_setup      <= 1'b1;
                    end else begin
                        o_cycle_count <= count_inc;
                        if (halt_seen) begin
                            state <= DONE;
                        end else if (limit_hit) begin
                            state     <= DONE;
                            o_timeout <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Count, timeout and data outputs stay frozen; only the core goes back to reset.
                    if (i_clear) begin
                        state        <= IDLE;
                        o_core_rst_n <= 1'b0;
                        o_setup      <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_boot_sequencer.sv
// Directed plus randomized bench for core_boot_sequencer with MAX_RUN_CYCLES=8.
// The expected values come from a plain "last command wins" model of the loader
// and from arithmetic on the halt cycle and the run limit.
module tb_core_boot_sequencer;

    localparam logic [31:0] HALT = 32'h00100073;
    localparam logic [31:0] NOP  = 32'h00000013;
    localparam int          LIM  = 8;
`ifdef CORE_BOOT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk, rst;
    logic        i_cmd_valid, o_cmd_ready;
    logic [1:0]  i_cmd_type;
    logic [31:0] i_cmd_addr, i_cmd_data;
    logic        i_clear;
    logic [31:0] i_core_inst;
    logic        o_core_rst_n, o_setup, o_running, o_done, o_timeout;
    logic [31:0] o_inst_mem_addr, o_inst_mem_data, o_load_reg_data, o_start_addr;
    logic [4:0]  o_load_reg_addr;
    logic [15:0] o_cycle_count;

    int passed = 0;
    int total  = 0;

    // Model of the loader-visible outputs.
    logic [31:0] m_ia, m_id, m_rd, m_sa;
    logic [4:0]  m_ra;

    core_boot_sequencer #(.HALT_INSTR(HALT), .CNT_W(16), .MAX_RUN_CYCLES(LIM)) dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_type(i_cmd_type), .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data),
        .i_clear(i_clear), .i_core_inst(i_core_inst),
        .o_core_rst_n(o_core_rst_n), .o_setup(o_setup),
        .o_inst_mem_addr(o_inst_mem_addr), .o_inst_mem_data(o_inst_mem_data),
        .o_load_reg_addr(o_load_reg_addr), .o_load_reg_data(o_load_reg_data),
        .o_start_addr(o_start_addr), .o_running(o_running), .o_done(o_done),
        .o_timeout(o_timeout), .o_cycle_count(o_cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one clock edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
        i_cmd_valid = 1'b1; i_cmd_type = t; i_cmd_addr = a; i_cmd_data = d;
        step();
        i_cmd_valid = 1'b0;
        case (t)
            2'd0: begin m_ia = a; m_id = d; end
            2'd1: begin m_ra = a[4:0]; m_rd = d; end
            2'd2: m_sa = d;
            default: ;
        endcase
    endtask

    task automatic chk_data(input string tag);
        chk({tag, "_ia"}, 64'(o_inst_mem_addr), 64'(m_ia));
        chk({tag, "_id"}, 64'(o_inst_mem_data), 64'(m_id));
        chk({tag, "_ra"}, 64'(o_load_reg_addr), 64'(m_ra));
        chk({tag, "_rd"}, 64'(o_load_reg_data), 64'(m_rd));
        chk({tag, "_sa"}, 64'(o_start_addr),    64'(m_sa));
    endtask

    function automatic logic [31:0] rnd_inst();
        logic [31:0] v = $urandom;
        return (v == HALT) ? NOP : v;
    endfunction

    initial begin
        int n, len;
        logic [1:0] t;
        m_ia = '0; m_id = '0; m_rd = '0; m_sa = '0; m_ra = '0;
        i_cmd_valid = 0; i_cmd_type = 0; i_cmd_addr = 0; i_cmd_data = 0;
        i_clear = 0; i_core_inst = NOP;

        // Reset with no clock edge yet
        rst = 1'b1;
        #2;
        chk("rst_core_rst_n", 64'(o_core_rst_n), 64'd0);
        chk("rst_setup",      64'(o_setup),      64'd1);
        chk("rst_ready",      64'(o_cmd_ready),  64'd1);
        chk("rst_done",       64'(o_done),       64'd0);
        chk("rst_running",    64'(o_running),    64'd0);
        chk("rst_timeout",    64'(o_timeout),    64'd0);
        chk("rst_count",      64'(o_cycle_count), 64'd0);
        chk_data("rst");
        rst = 1'b0;

        // Load sequence
        send(2'd0, 32'h0, 32'h00500093);
        chk("load_core_rst_n", 64'(o_core_rst_n), 64'd1);
        chk("load_setup",      64'(o_setup),      64'd1);
        chk_data("load1");
        send(2'd0, 32'h4, 32'h00100073);
        chk_data("load2");
        send(2'd1, 32'h2, 32'hDEAD);
        chk_data("load3");
        send(2'd2, 32'h0, 32'h0);
        chk("start_running", 64'(o_running), 64'd1);
        chk("start_setup",   64'(o_setup),   64'd0);
        chk("start_ready",   64'(o_cmd_ready), 64'd0);
        chk_data("start");

        // Halt on the 3rd RUN cycle
        step(); step();
        i_core_inst = HALT;
        step();
        i_core_inst = NOP;
        chk("halt_done",    64'(o_done),        64'd1);
        chk("halt_count",   64'(o_cycle_count), 64'd3);
        chk("halt_ready",   64'(o_cmd_ready),   64'd0);
        chk("halt_timeout", 64'(o_timeout),     64'd0);

        // Commands offered in DONE are ignored
        i_cmd_valid = 1'b1; i_cmd_type = 2'd0; i_cmd_addr = 32'h100; i_cmd_data = 32'h55;
        step();
        i_cmd_valid = 1'b0;
        chk_data("done_bp");
        chk("done_bp_count", 64'(o_cycle_count), 64'd3);

        // Clear from DONE
        i_clear = 1'b1; step(); i_clear = 1'b0;
        chk("clr_done",      64'(o_done),        64'd0);
        chk("clr_ready",     64'(o_cmd_ready),   64'd1);
        chk("clr_core_rst",  64'(o_core_rst_n),  64'd0);
        chk("clr_count",     64'(o_cycle_count), 64'd3);

        // Reserved command in LOAD changes nothing
        send(2'd0, 32'h8, 32'h11);
        send(2'd3, 32'hFF, 32'hFFFFFFFF);
        chk_data("rsv");
        chk("rsv_setup",   64'(o_setup),   64'd1);
        chk("rsv_running", 64'(o_running), 64'd0);
        chk("rsv_ready",   64'(o_cmd_ready), 64'd1);

        // Valid held during RUN, then clear on RUN cycle 5
        send(2'd2, 32'h0, 32'h40);
        i_cmd_valid = 1'b1; i_cmd_type = 2'd1; i_cmd_addr = 32'h7; i_cmd_data = 32'h77;
        for (int i = 0; i < 4; i++) step();
        chk_data("run_bp");
        chk("run_bp_count", 64'(o_cycle_count), 64'd4);
        i_clear = 1'b1; step(); i_clear = 1'b0; i_cmd_valid = 1'b0;
        chk("abort_running", 64'(o_running),    64'd0);
        chk("abort_core_rst", 64'(o_core_rst_n), 64'd0);
        chk("abort_setup",   64'(o_setup),      64'd1);
        chk_data("abort");

        // Asynchronous reset in the middle of LOAD
        send(2'd0, 32'hC, 32'h22);
        #2; rst = 1'b1; #1;
        m_ia = '0; m_id = '0; m_ra = '0; m_rd = '0; m_sa = '0;
        chk_data("arst");
        chk("arst_core_rst", 64'(o_core_rst_n), 64'd0);
        chk("arst_setup",    64'(o_setup),      64'd1);
        chk("arst_count",    64'(o_cycle_count), 64'd0);
        rst = 1'b0;

        // Long run without halt
        send(2'd2, 32'h0, 32'h0);
        if (TO_EN) begin
            for (int i = 0; i < LIM - 1; i++) step();
            chk("to_pre_running", 64'(o_running), 64'd1);
            step();
            chk("to_done",    64'(o_done),        64'd1);
            chk("to_timeout", 64'(o_timeout),     64'd1);
            chk("to_count",   64'(o_cycle_count), 64'(LIM));
            step();
            chk("to_frozen",  64'(o_cycle_count), 64'(LIM));
            i_clear = 1'b1; step(); i_clear = 1'b0;
            send(2'd2, 32'h0, 32'h0);
            for (int i = 0; i < LIM - 1; i++) step();
            i_core_inst = HALT; step(); i_core_inst = NOP;
            chk("to_halt_done",    64'(o_done),        64'd1);
            chk("to_halt_timeout", 64'(o_timeout),     64'd0);
            chk("to_halt_count",   64'(o_cycle_count), 64'(LIM));
        end else begin
            for (int i = 0; i < 20; i++) step();
            chk("nolim_running", 64'(o_running),     64'd1);
            chk("nolim_count",   64'(o_cycle_count), 64'd20);
            i_core_inst = HALT; step(); i_core_inst = NOP;
            chk("nolim_done",    64'(o_done),        64'd1);
            chk("nolim_timeout", 64'(o_timeout),     64'd0);
            chk("nolim_count2",  64'(o_cycle_count), 64'd21);
        end
        i_clear = 1'b1; step(); i_clear = 1'b0;

        // Randomized load/run sessions
        for (int it = 0; it < 20; it++) begin
            n = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) begin
                case ($urandom_range(0, 2))
                    0: t = 2'd0;
                    1: t = 2'd1;
                    default: t = 2'd3;
                endcase
                send(t, $urandom, $urandom);
                chk_data("rnd_load");
            end
            send(2'd2, $urandom, $urandom);
            chk_data("rnd_start");
            n = $urandom_range(1, 12);
            len = (TO_EN && n > LIM) ? LIM : n;
            for (int c = 1; c <= len; c++) begin
                i_core_inst = (c == n) ? HALT : rnd_inst();
                step();
            end
            i_core_inst = NOP;
            chk("rnd_done",    64'(o_done),        64'd1);
            chk("rnd_count",   64'(o_cycle_count), 64'(len));
            chk("rnd_timeout", 64'(o_timeout),     64'(len != n));
            i_clear = 1'b1; step(); i_clear = 1'b0;
            chk("rnd_clr_ready", 64'(o_cmd_ready), 64'd1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
